// File: rtl/mp_add_pkg.sv
// rtl/mp_add_pkg.sv - shared types and defaults for the multi-precision add sequencer
package mp_add_pkg;

   localparam int MP_ADD_W_DEFAULT = 16;

   typedef enum logic {
      ST_FIRST = 1'b0,
      ST_CONT  = 1'b1
   } mp_add_st_e;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - N-bit combinational ripple-carry adder slice
module full_adder #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mp_add_seq.sv
// rtl/mp_add_seq.sv - chains multi-word operands through one adder slice, LSW first
module mp_add_seq
   import mp_add_pkg::*;
#(
   parameter int W     = MP_ADD_W_DEFAULT,
   parameter int WORDS = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_last,
   input  logic         in_cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_last,
   output logic         out_cout,
   output logic         out_err,
   output logic         busy
);

   localparam int             CW       = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(WORDS - 1);

   mp_add_st_e    st_q, st_d;
   logic          c_q, c_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_sum_q, out_sum_d;
   logic          out_last_q, out_last_d;
   logic          out_cout_q, out_cout_d;
   logic          out_err_q, out_err_d;

   logic [W-1:0]  s;
   logic          co;
   logic          slice_cin;
   logic          term;
   logic          accept;

   // The first word of an operation takes the external carry; later words chain the stored one.
   assign slice_cin = (st_q == ST_CONT) ? c_q : in_cin;

   full_adder #(.N(W)) u_slice (
      .a   (in_a),
      .b   (in_b),
      .cin (slice_cin),
      .s   (s),
      .co  (co)
   );

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign term     = in_last || (cnt_q == CNT_LAST);

   always_comb begin
      st_d        = st_q;
      c_d         = c_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_last_d  = out_last_q;
      out_cout_d  = out_cout_q;
      out_err_d   = out_err_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_sum_d   = s;
         out_last_d  = term;
         out_cout_d  = term ? co : 1'b0;
         out_err_d   = term && !in_last;
         c_d         = co;
         if (term) begin
            st_d  = ST_FIRST;
            cnt_d = '0;
         end else begin
            st_d  = ST_CONT;
            cnt_d = cnt_q + 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q        <= ST_FIRST;
         c_q         <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_last_q  <= 1'b0;
         out_cout_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         st_q        <= st_d;
         c_q         <= c_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_last_q  <= out_last_d;
         out_cout_q  <= out_cout_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_last  = out_last_q;
   assign out_cout  = out_cout_q;
   assign out_err   = out_err_q;
   assign busy      = (st_q == ST_CONT);

endmodule
